// File: rtl/rr_ffs_arbiter.sv
// rr_ffs_arbiter: round-robin arbiter for NREQ requesters.
// A rotating find-first-set search starts at the requester after the last
// grantee and wraps around. A grant is held until the grantee asserts
// i_release, and every grant is followed by at least one idle cycle.
// The output index drives the select mux of the shared resource.
// Optional feature: define RR_ARB_TIMEOUT_EN to add a watchdog that forces a
// release after TIMEOUT busy cycles and pulses o_timeout for that cycle.
module rr_ffs_arbiter #(
    parameter int NREQ    = 8,
    parameter int TIMEOUT = 16,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_release,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_grant_valid,
    output logic            o_timeout
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;

    logic          w_found;
    logic [IW-1:0] w_found_idx;
    logic [IW:0]   w_cand;

    logic          w_expire;
    logic          w_release;

    // Rotating search: candidates r_ptr, r_ptr+1, ... wrapped at NREQ.
    // The sum is formed one bit wider than the index so NREQ-1 + offset
    // cannot overflow before the wrap compare.
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = '0;
        w_cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(NREQ)) begin
                w_cand = w_cand - (IW+1)'(NREQ);
            end
            if (!w_found && i_req[w_cand[IW-1:0]]) begin
                w_found     = 1'b1;
                w_found_idx = w_cand[IW-1:0];
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Watchdog fires only when the grantee has not released on its own,
    // so a coincident release is a normal release with no timeout pulse.
    assign w_expire = (r_state == S_BUSY) && !i_release &&
                      (r_cnt == CW'(TIMEOUT));

    // Busy-cycle counter: held at zero while idle so it starts from zero
    // on every entry to BUSY.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_state != S_BUSY || w_release) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    assign w_release = i_release || w_expire;
    assign o_timeout = w_expire;

    // Next-state logic: grant on a hit in IDLE, hold in BUSY until release.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_idx_nxt   = w_found_idx;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_ptr_nxt   = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State, grantee index and search pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign o_grant_valid = (r_state == S_BUSY);
    assign o_grant_idx   = r_idx;

    // One-hot grant decoded from the registered index; zero when idle.
    always_comb begin
        o_grant = '0;
        if (r_state == S_BUSY) begin
            o_grant[r_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_ffs_arbiter.sv
// Testbench for rr_ffs_arbiter: an 8-requester and a 5-requester instance,
// each compared every cycle against a queue-free behavioural model that
// searches with modulo arithmetic. Set RR_ARB_TIMEOUT_EN to test the watchdog.
module tb_rr_ffs_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req8;
    logic       rel8;
    logic [4:0] req5;
    logic       rel5;

    logic [7:0] g8;
    logic [2:0] gi8;
    logic       gv8;
    logic       to8;
    logic [4:0] g5;
    logic [2:0] gi5;
    logic       gv5;
    logic       to5;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = 8-way, index 1 = 5-way
    bit m_busy[2];
    int m_idx[2];
    int m_ptr[2];
    int m_cnt[2];

    rr_ffs_arbiter #(.NREQ(8), .TIMEOUT(TO)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_req(req8), .i_release(rel8),
        .o_grant(g8), .o_grant_idx(gi8), .o_grant_valid(gv8), .o_timeout(to8)
    );

    rr_ffs_arbiter #(.NREQ(5), .TIMEOUT(TO)) u_dut5 (
        .i_clk(clk), .i_rst(rst), .i_req(req5), .i_release(rel5),
        .o_grant(g5), .o_grant_idx(gi5), .o_grant_valid(gv5), .o_timeout(to5)
    );

    always #5 clk = ~clk;

    function automatic int nreq(int d);
        return (d == 0) ? 8 : 5;
    endfunction

    function automatic logic [7:0] cur_req(int d);
        return (d == 0) ? req8 : {3'b000, req5};
    endfunction

    function automatic bit cur_rel(int d);
        return (d == 0) ? rel8 : rel5;
    endfunction

    // first requester at or after ptr, wrapping; -1 when none
    function automatic int find_next(int d);
        logic [7:0] r;
        int n;
        r = cur_req(d);
        n = nreq(d);
        for (int k = 0; k < n; k++) begin
            if (r[(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
        end
        return -1;
    endfunction

    function automatic bit exp_to(int d);
`ifdef RR_ARB_TIMEOUT_EN
        return m_busy[d] && !cur_rel(d) && (m_cnt[d] == TO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [12:0] exp8();
        logic [7:0] g;
        g = m_busy[0] ? (8'h01 << m_idx[0]) : 8'h00;
        return {m_busy[0], 3'(m_idx[0]), g, exp_to(0)};
    endfunction

    function automatic logic [9:0] exp5();
        logic [4:0] g;
        g = m_busy[1] ? (5'h01 << m_idx[1]) : 5'h00;
        return {m_busy[1], 3'(m_idx[1]), g, exp_to(1)};
    endfunction

    task automatic model_step(int d);
        int f;
        bit forced;
        if (rst) begin
            m_busy[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
        end else if (!m_busy[d]) begin
            f = find_next(d);
            if (f >= 0) begin
                m_busy[d] = 1; m_idx[d] = f; m_cnt[d] = 0;
            end
        end else begin
            forced = exp_to(d);
            if (cur_rel(d) || forced) begin
                m_busy[d] = 0;
                m_ptr[d]  = (m_idx[d] + 1) % nreq(d);
                m_idx[d]  = 0;
                m_cnt[d]  = 0;
            end else begin
                m_cnt[d] = m_cnt[d] + 1;
            end
        end
    endtask

    // one clock: model sees the same inputs the DUT samples, outputs settle
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req8 = '0; rel8 = 1'b0; req5 = '0; rel5 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req8 = 8'hFF; rel8 = 1'b0; req5 = 5'h1F; rel5 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({gv8, gi8, g8, to8} !== 13'h0) begin
                bad++;
                $display("FAIL reset8 c%0d: got %h want 0", c, {gv8, gi8, g8, to8});
            end
            total++;
            if ({gv5, gi5, g5, to5} !== 10'h0) begin
                bad++;
                $display("FAIL reset5 c%0d: got %h want 0", c, {gv5, gi5, g5, to5});
            end
        end
        rst = 1'b0;
        #2;
        total++;
        if ({gv8, gi8, g8} !== 12'h0) begin
            bad++;
            $display("FAIL reset_fall: got %h want 0", {gv8, gi8, g8});
        end
        tick();
        total++;
        if (gv8 !== 1'b1 || gi8 !== 3'd0 || g8 !== 8'h01 || {gv8, gi8, g8, to8} !== exp8()) begin
            bad++;
            $display("FAIL first_grant: got v=%b i=%0d g=%h want v=1 i=0 g=01", gv8, gi8, g8);
        end
    endtask

    task automatic test_rotation();
        int seq[9];
        int n;
        bit prev;
        do_reset();
        req8 = 8'hFF;
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && n < 9; c++) begin
            rel8 = gv8;
            tick();
            total++;
            if ({gv8, gi8, g8, to8} !== exp8()) begin
                bad++;
                $display("FAIL rotation c%0d: got %h want %h", c, {gv8, gi8, g8, to8}, exp8());
            end
            if (gv8 && prev) begin
                total++; bad++;
                $display("FAIL rotation_idle c%0d: got back-to-back grant want idle gap", c);
            end
            if (gv8) begin
                seq[n] = int'(gi8);
                n++;
            end
            prev = gv8;
        end
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL rotation_count: got %0d grants want 9", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (seq[k] != k % 8) begin
                bad++;
                $display("FAIL rotation_seq[%0d]: got %0d want %0d", k, seq[k], k % 8);
            end
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        req8 = '0;
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req8 = 8'h20;
        tick();
        total++;
        if (gi8 !== 3'd5 || gv8 !== 1'b1) begin
            bad++;
            $display("FAIL skip_g5: got v=%b i=%0d want v=1 i=5", gv8, gi8);
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        req8 = 8'b0000_1001;
        tick();
        total++;
        if (gi8 !== 3'd0 || g8 !== 8'h01 || {gv8, gi8, g8, to8} !== exp8()) begin
            bad++;
            $display("FAIL skip_wrap0: got i=%0d g=%h want i=0 g=01", gi8, g8);
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        tick();
        total++;
        if (gi8 !== 3'd3 || g8 !== 8'h08 || {gv8, gi8, g8, to8} !== exp8()) begin
            bad++;
            $display("FAIL skip_next3: got i=%0d g=%h want i=3 g=08", gi8, g8);
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        req8 = '0;
    endtask

    task automatic test_hold();
        do_reset();
        req8 = 8'h04;
        tick();
        req8 = 8'h80;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (g8 !== 8'h04 || gi8 !== 3'd2 || gv8 !== 1'b1) begin
                bad++;
                $display("FAIL hold c%0d: got g=%h i=%0d want g=04 i=2", c, g8, gi8);
            end
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        total++;
        if ({gv8, g8} !== 9'h0) begin
            bad++;
            $display("FAIL hold_release: got v=%b g=%h want 0", gv8, g8);
        end
        tick();
        total++;
        if (gi8 !== 3'd7 || g8 !== 8'h80 || {gv8, gi8, g8, to8} !== exp8()) begin
            bad++;
            $display("FAIL hold_next7: got i=%0d g=%h want i=7 g=80", gi8, g8);
        end
        rel8 = 1'b1;
        tick();
        rel8 = 1'b0;
        req8 = '0;
    endtask

    task automatic test_npo2();
        do_reset();
        req5 = 5'b10000;
        tick();
        total++;
        if (gi5 !== 3'd4 || g5 !== 5'h10) begin
            bad++;
            $display("FAIL npo2_g4: got i=%0d g=%h want i=4 g=10", gi5, g5);
        end
        rel5 = 1'b1;
        tick();
        rel5 = 1'b0;
        req5 = 5'b10001;
        tick();
        total++;
        if (gi5 !== 3'd0 || g5 !== 5'h01 || {gv5, gi5, g5, to5} !== exp5()) begin
            bad++;
            $display("FAIL npo2_wrap: got i=%0d g=%h want i=0 g=01", gi5, g5);
        end
        for (int c = 0; c < 200; c++) begin
            req5 = 5'($urandom);
            rel5 = ($urandom_range(0, 2) == 0);
            tick();
            total++;
            if ({gv5, gi5, g5, to5} !== exp5() || gi5 > 3'd4) begin
                bad++;
                $display("FAIL npo2_rand c%0d: got %h want %h", c, {gv5, gi5, g5, to5}, exp5());
            end
        end
        req5 = '0;
        rel5 = 1'b1;
        tick();
        rel5 = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses;
        bit saw1;
        do_reset();
        req8 = 8'h03;
        tick();
        pulses = 0;
        saw1 = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if ({gv8, gi8, g8, to8} !== exp8()) begin
                bad++;
                $display("FAIL timeout c%0d: got %h want %h", c, {gv8, gi8, g8, to8}, exp8());
            end
            if (to8) pulses++;
            if (gv8 && gi8 == 3'd1) saw1 = 1'b1;
        end
        total++;
        if (pulses != 1 || !saw1) begin
            bad++;
            $display("FAIL timeout_pulse: got pulses=%0d served1=%b want 1 1", pulses, saw1);
        end
`else
        for (int c = 0; c < 22; c++) begin
            tick();
            total++;
            if (gv8 !== 1'b1 || gi8 !== 3'd0 || to8 !== 1'b0) begin
                bad++;
                $display("FAIL no_timeout c%0d: got v=%b i=%0d t=%b want 1 0 0", c, gv8, gi8, to8);
            end
        end
`endif
        rel8 = 1'b1;
        req8 = '0;
        tick();
        rel8 = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req8 = 8'($urandom);
            rel8 = ($urandom_range(0, 9) < 3);
            req5 = 5'($urandom);
            rel5 = ($urandom_range(0, 9) < 3);
            tick();
            total++;
            if ({gv8, gi8, g8, to8} !== exp8()) begin
                bad++;
                $display("FAIL random8 c%0d: got %h want %h", c, {gv8, gi8, g8, to8}, exp8());
            end
            total++;
            if ({gv5, gi5, g5, to5} !== exp5()) begin
                bad++;
                $display("FAIL random5 c%0d: got %h want %h", c, {gv5, gi5, g5, to5}, exp5());
            end
            total++;
            if (g8 !== (gv8 ? (8'h01 << gi8) : 8'h00)) begin
                bad++;
                $display("FAIL invariant8 c%0d: got g=%h v=%b i=%0d", c, g8, gv8, gi8);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_busy[0] = 0; m_busy[1] = 0;
        m_idx[0] = 0;  m_idx[1] = 0;
        m_ptr[0] = 0;  m_ptr[1] = 0;
        m_cnt[0] = 0;  m_cnt[1] = 0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_hold();
        test_npo2();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
